// File: rtl/goboard_io_pkg.sv
// goboard_io_pkg: event word layout shared by the button input block and its CPU driver
package goboard_io_pkg;
  localparam int EVT_VALID_BIT = 15;
  localparam int EVT_OVF_BIT = 14;
  localparam int EVT_PRESS_BIT = 13;
  localparam int EVT_IDX_LSB = 8;
  typedef struct packed {
    logic valid;
    logic ovf;
    logic press;
    logic rsvd;
    logic [3:0] idx;
    logic [7:0] held;
  } button_event_t;
endpackage

// File: rtl/goboard_button_input_if.sv
// goboard_button_input_if: CPU read handshake and status of the button event queue
interface goboard_button_input_if;
  logic rdReq;
  logic [15:0] rdData;
  logic rdValid;
  logic eventPending;
  logic overflow;
  modport master(output rdReq, input rdData, rdValid, eventPending, overflow);
  modport slave(input rdReq, output rdData, rdValid, eventPending, overflow);
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchroniser plus stable-count debounce for one button pin
module button_debouncer #(
  parameter int CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic held,
  output logic change
);
  localparam int CW = $clog2(CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_comb change = (sync[1] != held) && (cnt == CW'(CYCLES - 1));
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
      held <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], pin};
      held <= change ? sync[1] : held;
      cnt <= (sync[1] == held || change) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/goboard_button_input.sv
// goboard_button_input: debounced push-buttons feeding a press/release event FIFO read by the CPU
module goboard_button_input
  import goboard_io_pkg::*;
#(
  parameter int NUM_BUTTONS = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic [NUM_BUTTONS-1:0] held,
  goboard_button_input_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, RESP} rd_state_t;
  rd_state_t state, state_next;
  logic [NUM_BUTTONS-1:0] change, pending, pick_hot;
  logic [3:0] pick_idx;
  logic [15:0] held_ext, push_word, resp;
  logic [AW:0] wp, rp, wp_next, rp_next;
  logic empty, full, push_req, pop, push, drop;
  button_event_t mem [FIFO_DEPTH];
  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_deb
    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk),
      .rst(rst),
      .pin(button[g]),
      .held(held[g]),
      .change(change[g])
    );
  end
  // lowest-index pending button wins the single push slot each cycle
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_BUTTONS - 1; k >= 0; k--) pick_idx = pending[k] ? 4'(k) : pick_idx;
    pick_hot = NUM_BUTTONS'(1) << pick_idx;
    held_ext = 16'(held);
    empty = wp == rp;
    full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    push_req = |pending;
    pop = bus.rdReq && !empty;
    push = push_req && (!full || pop);
    drop = push_req && full && !pop;
    wp_next = wp + {{AW{1'b0}}, push};
    rp_next = rp + {{AW{1'b0}}, pop};
    push_word = {8'h00, held_ext[7:0]};
    push_word[EVT_VALID_BIT] = 1'b1;
    push_word[EVT_PRESS_BIT] = held_ext[pick_idx];
    push_word[EVT_IDX_LSB +: 4] = pick_idx;
    resp = empty ? '0 : mem[rp[AW-1:0]];
    resp[EVT_OVF_BIT] = bus.overflow;
  end
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_next;
  end
  always_comb state_next = bus.rdReq ? RESP : IDLE;
  always_comb bus.rdValid = state == RESP;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      pending <= '0;
      bus.overflow <= 1'b0;
      bus.eventPending <= 1'b0;
      bus.rdData <= '0;
    end else begin
      wp <= wp_next;
      rp <= rp_next;
      pending <= (pending & ~pick_hot) | change;
      bus.overflow <= drop || (bus.overflow && !bus.rdReq);
      bus.eventPending <= wp_next != rp_next;
      if (bus.rdReq) bus.rdData <= resp;
    end
  end
  always_ff @(posedge clk) if (push) mem[wp[AW-1:0]] <= push_word;
endmodule

// File: tb/tb_goboard_button_input.sv
// tb_goboard_button_input: directed scenarios plus random traffic against a queue-based event model
module tb_goboard_button_input;
  localparam int NB = 4;
  localparam int DB = 8;
  localparam int FD = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NB-1:0] button = '0;
  logic [NB-1:0] held;
  int compared = 0;
  int mismatched = 0;
  goboard_button_input_if bus();
  goboard_button_input #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .held(held),
    .bus(bus)
  );
  always #5 clk = ~clk;

  // reference: a level is accepted after DB consecutive disagreeing synchronised samples;
  // accepted changes wait in a pending list and move one per cycle into a bounded queue
  logic [NB-1:0] m_held, hist0, hist1;
  int run [NB];
  int pend [$];
  logic [15:0] fifo [$];
  logic m_ovf, m_valid;
  logic [15:0] m_data;
  always @(posedge clk) begin : model
    logic [15:0] w;
    bit dropped;
    int idx;
    if (!rst) begin
      m_held = '0; hist0 = '0; hist1 = '0;
      for (int i = 0; i < NB; i++) run[i] = 0;
      pend.delete(); fifo.delete();
      m_ovf = 1'b0; m_valid = 1'b0; m_data = '0;
    end else begin
      dropped = 0;
      m_valid = bus.rdReq;
      if (bus.rdReq) begin
        if (fifo.size() > 0) begin
          w = fifo.pop_front();
          m_data = {w[15], m_ovf, w[13:0]};
        end else m_data = {1'b0, m_ovf, 14'b0};
      end
      if (pend.size() > 0) begin
        idx = pend.pop_front();
        w = {1'b1, 1'b0, m_held[idx], 1'b0, 4'(idx), 4'b0, m_held};
        if (fifo.size() < FD) fifo.push_back(w);
        else dropped = 1;
      end
      m_ovf = dropped || (m_ovf && !bus.rdReq);
      for (int i = 0; i < NB; i++) begin
        if (hist1[i] != m_held[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            m_held[i] = hist1[i];
            run[i] = 0;
            pend.push_back(i);
          end
        end else run[i] = 0;
      end
      hist1 = hist0;
      hist0 = button;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; button = '0; bus.rdReq = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic settle();
    repeat (DB + 4) tick();
  endtask

  task automatic do_read(output logic [15:0] d, output logic v);
    bus.rdReq = 1'b1;
    tick();
    bus.rdReq = 1'b0;
    d = bus.rdData;
    v = bus.rdValid;
  endtask

  task automatic test_reset();
    rst = 1'b0; button = 4'hF; bus.rdReq = 1'b0;
    tick(); tick();
    compared += 5;
    if (held !== 4'h0) begin mismatched++; $display("FAIL reset_held: got %h expected 0", held); end
    if (bus.eventPending !== 1'b0) begin mismatched++; $display("FAIL reset_pending: got %b expected 0", bus.eventPending); end
    if (bus.overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
    if (bus.rdValid !== 1'b0) begin mismatched++; $display("FAIL reset_rdvalid: got %b expected 0", bus.rdValid); end
    if (bus.rdData !== 16'h0) begin mismatched++; $display("FAIL reset_rddata: got %h expected 0000", bus.rdData); end
    rst = 1'b1;
    repeat (DB + 1) tick();
    compared++;
    if (held !== 4'h0) begin mismatched++; $display("FAIL latency_early: got %h expected 0", held); end
    tick();
    compared++;
    if (held !== 4'hF) begin mismatched++; $display("FAIL latency_held: got %h expected f", held); end
    tick();
    compared++;
    if (bus.eventPending !== 1'b1) begin mismatched++; $display("FAIL latency_pending: got %b expected 1", bus.eventPending); end
  endtask

  task automatic test_bounce();
    logic [15:0] d;
    logic v;
    do_reset();
    repeat (10) begin
      button[1] = ~button[1];
      repeat (3) begin
        tick();
        compared++;
        if (held !== 4'h0 || bus.eventPending !== 1'b0) begin
          mismatched++;
          $display("FAIL bounce_quiet: held %h pending %b expected 0 0", held, bus.eventPending);
        end
      end
    end
    button[1] = 1'b1;
    settle();
    compared += 3;
    if (held !== 4'h2) begin mismatched++; $display("FAIL bounce_held: got %h expected 2", held); end
    do_read(d, v);
    if (d !== 16'hA102 || v !== 1'b1) begin mismatched++; $display("FAIL bounce_read: got %h/%b expected a102/1", d, v); end
    do_read(d, v);
    if (d !== 16'h0000) begin mismatched++; $display("FAIL bounce_single: got %h expected 0000", d); end
  endtask

  task automatic test_simultaneous();
    logic [15:0] d;
    logic v;
    logic [15:0] exp_w [3] = '{16'hA005, 16'hA205, 16'h0000};
    do_reset();
    button = 4'b0101;
    settle();
    for (int i = 0; i < 3; i++) begin
      do_read(d, v);
      compared++;
      if (d !== exp_w[i] || v !== 1'b1) begin
        mismatched++;
        $display("FAIL simul_read%0d: got %h/%b expected %h/1", i, d, v, exp_w[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    logic v;
    logic [15:0] exp_w [5] = '{16'hE001, 16'hA103, 16'hA207, 16'hA30F, 16'h0000};
    do_reset();
    for (int i = 0; i < NB; i++) begin
      button[i] = 1'b1;
      settle();
    end
    compared++;
    if (bus.overflow !== 1'b0 || bus.eventPending !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_full: overflow %b pending %b expected 0 1", bus.overflow, bus.eventPending);
    end
    button[0] = 1'b0;
    settle();
    compared++;
    if (bus.overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
    for (int i = 0; i < 5; i++) begin
      do_read(d, v);
      compared++;
      if (d !== exp_w[i]) begin mismatched++; $display("FAIL ovf_read%0d: got %h expected %h", i, d, exp_w[i]); end
      if (i == 0) begin
        compared++;
        if (bus.overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w [4] = '{16'hA003, 16'hA103, 16'h0000, 16'h0000};
    logic exp_v [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    button = 4'b0011;
    settle();
    bus.rdReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 2) bus.rdReq = 1'b0;
      compared++;
      if (bus.rdValid !== exp_v[i] || bus.rdData !== exp_w[i]) begin
        mismatched++;
        $display("FAIL b2b_cycle%0d: got %b/%h expected %b/%h", i, bus.rdValid, bus.rdData, exp_v[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    button = 4'b0100;
    settle();
    bus.rdReq = 1'b1;
    tick();
    compared++;
    if (bus.rdValid !== 1'b1 || bus.rdData !== 16'hA204) begin
      mismatched++;
      $display("FAIL midrst_resp: got %b/%h expected 1/a204", bus.rdValid, bus.rdData);
    end
    bus.rdReq = 1'b0;
    rst = 1'b0;
    tick();
    compared++;
    if (bus.rdValid !== 1'b0 || bus.eventPending !== 1'b0 || bus.rdData !== 16'h0) begin
      mismatched++;
      $display("FAIL midrst_clear: valid %b pending %b data %h expected 0 0 0000", bus.rdValid, bus.eventPending, bus.rdData);
    end
    rst = 1'b1;
  endtask

  task automatic test_random();
    int b;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, NB - 1);
        button[b] = ~button[b];
      end
      bus.rdReq = $urandom_range(0, 99) < (c < 1500 ? 4 : 40);
      tick();
      compared++;
      if (held !== m_held || bus.eventPending !== (fifo.size() > 0) || bus.overflow !== m_ovf ||
          bus.rdValid !== m_valid || bus.rdData !== m_data) begin
        mismatched++;
        $display("FAIL random_c%0d: held %h pend %b ovf %b val %b data %h expected %h %b %b %b %h",
                 c, held, bus.eventPending, bus.overflow, bus.rdValid, bus.rdData,
                 m_held, fifo.size() > 0, m_ovf, m_valid, m_data);
      end
    end
    bus.rdReq = 1'b0;
  endtask

  initial begin
    bus.rdReq = 1'b0;
    test_reset();
    test_bounce();
    test_simultaneous();
    test_overflow();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
